dmem_router: RTL and testbench
==============================

// Module: dmem_router
// PURPOSE
//  Parametrised data-port address router between the core dmem port and N memory-mapped targets
//  (main memory, TFT text RAM, ...). Replaces ad-hoc top-level decode with a per-region match,
//  base-relative address translation and read-return muxing aligned to target read latency.
//  Adds an exit mailbox (halt + exit code) and unmapped-access fault capture.
// PARAMETERS
//  N_REGIONS       3                                   number of targets
//  REGION_BASE     {32'h8000_0000,32'h2000_0000,32'h0} packed N*32; region i base (LSB slice = region 0)
//  REGION_SIZE     {32'h0000_1000,32'h0000_1000,32'h2000_0000} packed N*32; region i size in bytes, non-zero
//  READ_LATENCY    1                                   cycles from data_en to valid target data_o, >=1
//  EXIT_ADDR       32'h600d600c                        exit mailbox address
//  UNMAPPED_RDATA  32'hdeadbeef                        read data returned for unmapped reads
// PORTS
//  clk          in   1       core clock
//  reset        in   1       asynchronous, active-high
//  addr         in   32      core byte address
//  data_i       in   32      core write data
//  data_en      in   1       access request (read or write)
//  write_en     in   1       write strobe, qualified by data_en
//  data_o       out  32      read return data
//  rvalid       out  1       data_o valid this cycle
//  t_addr       out  N*32    per-target address = addr - REGION_BASE[i]
//  t_data_i     out  32      write data broadcast to all targets
//  t_data_en    out  N       per-target request
//  t_write_en   out  N       per-target write strobe
//  t_data_o     in   N*32    per-target read data
//  done         out  1       sticky: exit mailbox written
//  exit_code    out  32      data written to EXIT_ADDR
//  fault        out  1       sticky: unmapped access seen
//  fault_addr   out  32      address of FIRST unmapped access
//  fault_count  out  8       unmapped accesses, saturates at 8'hFF
// BEHAVIOUR
//  - Match: hit[i] = (addr >= BASE[i]) && ({1'b0,addr} < {1'b0,BASE[i]} + SIZE[i]); 33-bit sum, no wrap.
//  - Selection priority: EXIT_ADDR first, then lowest-index hit region, else unmapped.
//  - Target strobes combinational: t_data_en[i]/t_write_en[i] asserted only for the selected region,
//    only when data_en=1; non-selected targets see 0. Exit or unmapped accesses strobe no target.
//  - t_addr[i] always driven (addr - BASE[i], mod 2^32) regardless of selection.
//  - Read pipeline: READ_LATENCY-deep shift register of {valid, sel_kind, sel_idx, snap}; entry pushed
//    every cycle, valid = data_en & !write_en. Output stage drives rvalid and data_o:
//      region   -> t_data_o[sel_idx] sampled at output stage (combinational from t_data_o)
//      exit     -> exit_code value snapshotted at issue cycle
//      unmapped -> UNMAPPED_RDATA
//    rvalid=0 -> data_o=0. Back-to-back reads every cycle supported, 1 result per cycle, in order.
//  - Exit write (data_en&write_en&addr==EXIT_ADDR): next edge done<=1, exit_code<=data_i. Later exit
//    writes update exit_code; done stays 1 until reset.
//  - Unmapped access (read or write): next edge fault<=1, fault_count<=sat(+1); fault_addr captured
//    only when fault was 0 (first fault kept). Exit address never counts as a fault.
//  - Writes produce no rvalid. write_en without data_en ignored entirely.
//  - Reset (async, any cycle incl. mid-read): pipeline cleared, rvalid=0, data_o=0, done=0,
//    exit_code=0, fault=0, fault_addr=0, fault_count=0. In-flight reads are dropped, not replayed.
//    Combinational target strobes follow inputs during reset; core is held in reset concurrently.
// TESTING
//  1 Write 0x1234 to 0x0000_0010 -> t_write_en=3'b001, t_addr[0]=0x10; read back -> rvalid and
//    data_o=0x1234 exactly READ_LATENCY cycles after request.
//  2 Write 0x41 to 0x2000_0004 -> t_write_en=3'b010, t_addr[1]=0x4; main memory not written.
//  3 Write 0x7 to 0x600d600c -> done=1, exit_code=7 next cycle, no t_write_en; read EXIT_ADDR -> 0x7.
//  4 Read 0x4000_0000 then write 0x5000_0000 -> data_o=0xdeadbeef with rvalid, fault=1,
//    fault_addr=0x4000_0000, fault_count=2; 300 more -> fault_count=0xFF.
//  5 Back-to-back reads regions 0,1,2,unmapped on 4 consecutive cycles with READ_LATENCY=2 -> 4
//    consecutive rvalid cycles, data in issue order from correct targets.
//  6 Assert reset while 1 read in flight -> rvalid never asserts for it; all sticky outputs 0.

Source files
------------

// File: rtl/dmem_router.sv
// Data-port address router: per-region decode, base-relative translation, latency-aligned read
// return muxing, exit mailbox and unmapped-access fault capture.
module dmem_router #(
  parameter int unsigned N_REGIONS = 3,
  parameter logic [N_REGIONS*32-1:0] REGION_BASE = {32'h8000_0000, 32'h2000_0000, 32'h0000_0000},
  parameter logic [N_REGIONS*32-1:0] REGION_SIZE = {32'h0000_1000, 32'h0000_1000, 32'h2000_0000},
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] EXIT_ADDR = 32'h600d_600c,
  parameter logic [31:0] UNMAPPED_RDATA = 32'hdead_beef
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             addr,
  input  logic [31:0]             data_i,
  input  logic                    data_en,
  input  logic                    write_en,
  output logic [31:0]             data_o,
  output logic                    rvalid,
  output logic [N_REGIONS*32-1:0] t_addr,
  output logic [31:0]             t_data_i,
  output logic [N_REGIONS-1:0]    t_data_en,
  output logic [N_REGIONS-1:0]    t_write_en,
  input  logic [N_REGIONS*32-1:0] t_data_o,
  output logic                    done,
  output logic [31:0]             exit_code,
  output logic                    fault,
  output logic [31:0]             fault_addr,
  output logic [7:0]              fault_count
);

  localparam int unsigned IW    = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int unsigned NSLOT = 2 ** IW;
  localparam int unsigned LAST  = READ_LATENCY - 1;

  typedef enum logic [1:0] {
    K_REGION = 2'd0,
    K_EXIT   = 2'd1,
    K_UNMAP  = 2'd2
  } kind_e;

  logic [N_REGIONS-1:0] w_hit;
  logic [31:0]          w_tdo [NSLOT];
  logic [IW-1:0]        w_sel_idx;
  logic                 w_any_hit;
  logic                 w_is_exit;
  kind_e                w_kind;
  logic                 w_exit_wr;
  logic                 w_unmap_acc;

  logic                 r_pv [READ_LATENCY];
  kind_e                r_pk [READ_LATENCY];
  logic [IW-1:0]        r_pi [READ_LATENCY];
  logic [31:0]          r_ps [READ_LATENCY];

  logic                 r_done;
  logic [31:0]          r_exit_code;
  logic                 r_fault;
  logic [31:0]          r_fault_addr;
  logic [7:0]           r_fault_count;

  // Per-region match (33-bit upper bound so a region ending at 2^32 does not wrap) and translation
  for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_region
    assign w_hit[gi] = (addr >= REGION_BASE[gi*32 +: 32]) &&
                       ({1'b0, addr} < ({1'b0, REGION_BASE[gi*32 +: 32]} +
                                        {1'b0, REGION_SIZE[gi*32 +: 32]}));
    assign t_addr[gi*32 +: 32] = addr - REGION_BASE[gi*32 +: 32];
  end

  for (genvar gs = 0; gs < NSLOT; gs++) begin : g_tdo
    if (gs < N_REGIONS) begin : g_used
      assign w_tdo[gs] = t_data_o[gs*32 +: 32];
    end else begin : g_pad
      assign w_tdo[gs] = '0;
    end
  end

  assign t_data_i = data_i;

  // Lowest-index hit wins; the exit mailbox overrides any region
  always_comb begin
    w_sel_idx = '0;
    w_any_hit = 1'b0;
    for (int i = int'(N_REGIONS) - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel_idx = IW'(i);
        w_any_hit = 1'b1;
      end
    end
    w_is_exit = (addr == EXIT_ADDR);
    if (w_is_exit)      w_kind = K_EXIT;
    else if (w_any_hit) w_kind = K_REGION;
    else                w_kind = K_UNMAP;
  end

  always_comb begin
    t_data_en  = '0;
    t_write_en = '0;
    if (data_en && (w_kind == K_REGION)) begin
      t_data_en[w_sel_idx]  = 1'b1;
      t_write_en[w_sel_idx] = write_en;
    end
  end

  assign w_exit_wr   = data_en & write_en & w_is_exit;
  assign w_unmap_acc = data_en & (w_kind == K_UNMAP);

  // Read pipeline: one entry pushed per cycle, aligned with target read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < int'(READ_LATENCY); s++) begin
        r_pv[s] <= 1'b0;
        r_pk[s] <= K_REGION;
        r_pi[s] <= '0;
        r_ps[s] <= '0;
      end
    end else begin
      r_pv[0] <= data_en & ~write_en;
      r_pk[0] <= w_kind;
      r_pi[0] <= w_sel_idx;
      r_ps[0] <= r_exit_code;
      for (int s = 1; s < int'(READ_LATENCY); s++) begin
        r_pv[s] <= r_pv[s-1];
        r_pk[s] <= r_pk[s-1];
        r_pi[s] <= r_pi[s-1];
        r_ps[s] <= r_ps[s-1];
      end
    end
  end

  always_comb begin
    rvalid = r_pv[LAST];
    data_o = '0;
    if (r_pv[LAST]) begin
      case (r_pk[LAST])
        K_REGION: data_o = w_tdo[r_pi[LAST]];
        K_EXIT:   data_o = r_ps[LAST];
        default:  data_o = UNMAPPED_RDATA;
      endcase
    end
  end

  // Exit mailbox and sticky fault capture (first fault address kept)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done        <= 1'b0;
      r_exit_code   <= '0;
      r_fault       <= 1'b0;
      r_fault_addr  <= '0;
      r_fault_count <= '0;
    end else begin
      if (w_exit_wr) begin
        r_done      <= 1'b1;
        r_exit_code <= data_i;
      end
      if (w_unmap_acc) begin
        r_fault <= 1'b1;
        if (!r_fault)               r_fault_addr  <= addr;
        if (r_fault_count != 8'hFF) r_fault_count <= r_fault_count + 8'd1;
      end
    end
  end

  assign done        = r_done;
  assign exit_code   = r_exit_code;
  assign fault       = r_fault;
  assign fault_addr  = r_fault_addr;
  assign fault_count = r_fault_count;

endmodule

// File: tb/tb_dmem_router.sv
// Directed bench for dmem_router: one instance at READ_LATENCY=1, one at READ_LATENCY=2,
// each with behavioural target memories of matching latency.
module tb_dmem_router;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, data_i;
  logic        data_en, write_en;

  logic [31:0] a_data_o, b_data_o, a_t_data_i, b_t_data_i;
  logic        a_rvalid, b_rvalid, a_done, b_done, a_fault, b_fault;
  logic [95:0] a_t_addr, b_t_addr, a_t_data_o, b_t_data_o;
  logic [2:0]  a_t_data_en, b_t_data_en, a_t_write_en, b_t_write_en;
  logic [31:0] a_exit_code, b_exit_code, a_fault_addr, b_fault_addr;
  logic [7:0]  a_fault_count, b_fault_count;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  dmem_router #(.READ_LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset), .addr(addr), .data_i(data_i), .data_en(data_en),
    .write_en(write_en), .data_o(a_data_o), .rvalid(a_rvalid), .t_addr(a_t_addr),
    .t_data_i(a_t_data_i), .t_data_en(a_t_data_en), .t_write_en(a_t_write_en),
    .t_data_o(a_t_data_o), .done(a_done), .exit_code(a_exit_code), .fault(a_fault),
    .fault_addr(a_fault_addr), .fault_count(a_fault_count));

  dmem_router #(.READ_LATENCY(2)) u_dut_b (
    .clk(clk), .reset(reset), .addr(addr), .data_i(data_i), .data_en(data_en),
    .write_en(write_en), .data_o(b_data_o), .rvalid(b_rvalid), .t_addr(b_t_addr),
    .t_data_i(b_t_data_i), .t_data_en(b_t_data_en), .t_write_en(b_t_write_en),
    .t_data_o(b_t_data_o), .done(b_done), .exit_code(b_exit_code), .fault(b_fault),
    .fault_addr(b_fault_addr), .fault_count(b_fault_count));

  // Target memories: word-indexed by translated address, 1-cycle (a) and 2-cycle (b) reads
  logic [31:0] a_mem [3][256];
  logic [31:0] b_mem [3][256];
  logic [31:0] a_rd [3];
  logic [31:0] b_rd1 [3];
  logic [31:0] b_rd2 [3];

  always @(posedge clk) begin
    for (int r = 0; r < 3; r++) begin
      if (a_t_data_en[r]) begin
        if (a_t_write_en[r]) a_mem[r][a_t_addr[r*32+2 +: 8]] <= a_t_data_i;
        else                 a_rd[r] <= a_mem[r][a_t_addr[r*32+2 +: 8]];
      end
      if (b_t_data_en[r]) begin
        if (b_t_write_en[r]) b_mem[r][b_t_addr[r*32+2 +: 8]] <= b_t_data_i;
        else                 b_rd1[r] <= b_mem[r][b_t_addr[r*32+2 +: 8]];
      end
      b_rd2[r] <= b_rd1[r];
    end
  end

  assign a_t_data_o = {a_rd[2], a_rd[1], a_rd[0]};
  assign b_t_data_o = {b_rd2[2], b_rd2[1], b_rd2[0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_en  = 1'b0;
    write_en = 1'b0;
    addr     = 32'h0;
    data_i   = 32'h0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
    addr     = a;
    data_i   = d;
    data_en  = 1'b1;
    write_en = we;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (3) tick();
    vec++; if (a_rvalid !== 1'b0) begin err++; $display("FAIL rst_rvalid got %h exp 0", a_rvalid); end
    vec++; if (a_data_o !== 32'h0) begin err++; $display("FAIL rst_data_o got %h exp 0", a_data_o); end
    vec++; if (a_done !== 1'b0) begin err++; $display("FAIL rst_done got %h exp 0", a_done); end
    vec++; if (a_exit_code !== 32'h0) begin err++; $display("FAIL rst_exit_code got %h exp 0", a_exit_code); end
    vec++; if (a_fault !== 1'b0) begin err++; $display("FAIL rst_fault got %h exp 0", a_fault); end
    vec++; if (a_fault_addr !== 32'h0) begin err++; $display("FAIL rst_fault_addr got %h exp 0", a_fault_addr); end
    vec++; if (a_fault_count !== 8'h0) begin err++; $display("FAIL rst_fault_count got %h exp 0", a_fault_count); end
    vec++; if (b_rvalid !== 1'b0) begin err++; $display("FAIL rst_b_rvalid got %h exp 0", b_rvalid); end
    vec++; if (a_t_addr[95:64] !== 32'h8000_0000) begin err++; $display("FAIL rst_t_addr2 got %h exp 80000000", a_t_addr[95:64]); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_region0();
    drive(32'h0000_0010, 32'h1234, 1'b1);
    #1;
    vec++; if (a_t_write_en !== 3'b001) begin err++; $display("FAIL t1_write_en got %b exp 001", a_t_write_en); end
    vec++; if (a_t_data_en !== 3'b001) begin err++; $display("FAIL t1_data_en got %b exp 001", a_t_data_en); end
    vec++; if (a_t_addr[31:0] !== 32'h10) begin err++; $display("FAIL t1_t_addr0 got %h exp 10", a_t_addr[31:0]); end
    tick();
    drive(32'h0000_0010, 32'h0, 1'b0);
    #1;
    vec++; if (a_t_write_en !== 3'b000) begin err++; $display("FAIL t1_rd_write_en got %b exp 000", a_t_write_en); end
    vec++; if (a_rvalid !== 1'b0) begin err++; $display("FAIL t1_wr_rvalid got %h exp 0", a_rvalid); end
    tick();
    idle();
    vec++; if (a_rvalid !== 1'b1) begin err++; $display("FAIL t1_rvalid got %h exp 1", a_rvalid); end
    vec++; if (a_data_o !== 32'h1234) begin err++; $display("FAIL t1_data_o got %h exp 1234", a_data_o); end
    vec++; if (b_rvalid !== 1'b0) begin err++; $display("FAIL t1_b_early got %h exp 0", b_rvalid); end
    tick();
    vec++; if (a_rvalid !== 1'b0) begin err++; $display("FAIL t1_rvalid_drop got %h exp 0", a_rvalid); end
    vec++; if (a_data_o !== 32'h0) begin err++; $display("FAIL t1_data_o_idle got %h exp 0", a_data_o); end
    vec++; if (b_rvalid !== 1'b1) begin err++; $display("FAIL t1_b_rvalid got %h exp 1", b_rvalid); end
    vec++; if (b_data_o !== 32'h1234) begin err++; $display("FAIL t1_b_data_o got %h exp 1234", b_data_o); end
    tick();
  endtask

  task automatic test_region1();
    drive(32'h2000_0004, 32'h41, 1'b1);
    #1;
    vec++; if (a_t_write_en !== 3'b010) begin err++; $display("FAIL t2_write_en got %b exp 010", a_t_write_en); end
    vec++; if (a_t_addr[63:32] !== 32'h4) begin err++; $display("FAIL t2_t_addr1 got %h exp 4", a_t_addr[63:32]); end
    vec++; if (a_t_addr[31:0] !== 32'h2000_0004) begin err++; $display("FAIL t2_t_addr0 got %h exp 20000004", a_t_addr[31:0]); end
    vec++; if (a_t_data_i !== 32'h41) begin err++; $display("FAIL t2_t_data_i got %h exp 41", a_t_data_i); end
    tick();
    drive(32'h2000_0004, 32'h0, 1'b0);
    tick();
    idle();
    vec++; if (a_data_o !== 32'h41) begin err++; $display("FAIL t2_readback got %h exp 41", a_data_o); end
    tick();
  endtask

  task automatic test_exit();
    drive(32'h600d_600c, 32'h7, 1'b1);
    #1;
    vec++; if (a_t_data_en !== 3'b000) begin err++; $display("FAIL t3_data_en got %b exp 000", a_t_data_en); end
    vec++; if (a_done !== 1'b0) begin err++; $display("FAIL t3_done_early got %h exp 0", a_done); end
    tick();
    drive(32'h600d_600c, 32'h0, 1'b0);
    vec++; if (a_done !== 1'b1) begin err++; $display("FAIL t3_done got %h exp 1", a_done); end
    vec++; if (a_exit_code !== 32'h7) begin err++; $display("FAIL t3_exit_code got %h exp 7", a_exit_code); end
    tick();
    idle();
    vec++; if (a_rvalid !== 1'b1) begin err++; $display("FAIL t3_rd_rvalid got %h exp 1", a_rvalid); end
    vec++; if (a_data_o !== 32'h7) begin err++; $display("FAIL t3_rd_data got %h exp 7", a_data_o); end
    vec++; if (a_fault !== 1'b0) begin err++; $display("FAIL t3_no_fault got %h exp 0", a_fault); end
    drive(32'h600d_600c, 32'h9, 1'b1);
    tick();
    idle();
    vec++; if (a_exit_code !== 32'h9) begin err++; $display("FAIL t3_exit_update got %h exp 9", a_exit_code); end
    vec++; if (a_done !== 1'b1) begin err++; $display("FAIL t3_done_sticky got %h exp 1", a_done); end
    tick();
  endtask

  task automatic test_unmapped();
    drive(32'h4000_0000, 32'h0, 1'b0);
    #1;
    vec++; if (a_t_data_en !== 3'b000) begin err++; $display("FAIL t4_data_en got %b exp 000", a_t_data_en); end
    tick();
    drive(32'h5000_0000, 32'h0, 1'b1);
    vec++; if (a_rvalid !== 1'b1) begin err++; $display("FAIL t4_rvalid got %h exp 1", a_rvalid); end
    vec++; if (a_data_o !== 32'hdead_beef) begin err++; $display("FAIL t4_data_o got %h exp deadbeef", a_data_o); end
    tick();
    data_en = 1'b0;
    addr    = 32'h4000_0000;
    vec++; if (a_fault !== 1'b1) begin err++; $display("FAIL t4_fault got %h exp 1", a_fault); end
    vec++; if (a_fault_addr !== 32'h4000_0000) begin err++; $display("FAIL t4_fault_addr got %h exp 40000000", a_fault_addr); end
    vec++; if (a_fault_count !== 8'd2) begin err++; $display("FAIL t4_fault_count got %h exp 02", a_fault_count); end
    vec++; if (a_rvalid !== 1'b0) begin err++; $display("FAIL t4_wr_rvalid got %h exp 0", a_rvalid); end
    tick();
    vec++; if (a_fault_count !== 8'd2) begin err++; $display("FAIL t4_we_no_en got %h exp 02", a_fault_count); end
    for (int k = 0; k < 300; k++) begin
      drive(32'h5000_0000 + 32'(k * 4), 32'h0, 1'b1);
      tick();
    end
    idle();
    vec++; if (a_fault_count !== 8'hFF) begin err++; $display("FAIL t4_saturate got %h exp ff", a_fault_count); end
    vec++; if (a_fault_addr !== 32'h4000_0000) begin err++; $display("FAIL t4_first_kept got %h exp 40000000", a_fault_addr); end
    tick();
  endtask

  task automatic test_boundaries();
    logic [31:0] ba [7];
    logic [2:0]  be [7];
    ba = '{32'h1FFF_FFFC, 32'h2000_0000, 32'h2000_0FFF, 32'h2000_1000,
           32'h8000_0FFC, 32'h8000_1000, 32'h600d_600c};
    be = '{3'b001, 3'b010, 3'b010, 3'b000, 3'b100, 3'b000, 3'b000};
    for (int k = 0; k < 7; k++) begin
      drive(ba[k], 32'h0, 1'b0);
      #1;
      vec++; if (a_t_data_en !== be[k]) begin err++; $display("FAIL bnd_%0d got %b exp %b", k, a_t_data_en, be[k]); end
      tick();
    end
    drive(32'h2000_0FFF, 32'h0, 1'b0);
    #1;
    vec++; if (a_t_addr[63:32] !== 32'hFFF) begin err++; $display("FAIL bnd_t_addr1 got %h exp fff", a_t_addr[63:32]); end
    tick();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra [4];
    logic [31:0] rd [4];
    ra = '{32'h0000_0020, 32'h2000_0008, 32'h8000_000C, 32'h4000_0004};
    rd = '{32'h0000_A0A0, 32'h0000_B1B1, 32'h0000_C2C2, 32'hdead_beef};
    for (int k = 0; k < 3; k++) begin
      drive(ra[k], rd[k], 1'b1);
      tick();
    end
    idle();
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(ra[k], 32'h0, 1'b0);
      else       idle();
      tick();
      if (k <= 3) begin
        vec++; if (a_rvalid !== 1'b1 || a_data_o !== rd[k]) begin err++; $display("FAIL b2b_a_%0d got %h/%h exp 1/%h", k, a_rvalid, a_data_o, rd[k]); end
      end else begin
        vec++; if (a_rvalid !== 1'b0) begin err++; $display("FAIL b2b_a_%0d got rvalid %h exp 0", k, a_rvalid); end
      end
      if (k >= 1 && k <= 4) begin
        vec++; if (b_rvalid !== 1'b1 || b_data_o !== rd[k-1]) begin err++; $display("FAIL b2b_b_%0d got %h/%h exp 1/%h", k, b_rvalid, b_data_o, rd[k-1]); end
      end else begin
        vec++; if (b_rvalid !== 1'b0) begin err++; $display("FAIL b2b_b_%0d got rvalid %h exp 0", k, b_rvalid); end
      end
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    drive(32'h0000_0020, 32'h0, 1'b0);
    tick();
    idle();
    #1;
    reset = 1'b1;
    #1;
    vec++; if (a_rvalid !== 1'b0) begin err++; $display("FAIL t6_a_rvalid got %h exp 0", a_rvalid); end
    vec++; if (a_data_o !== 32'h0) begin err++; $display("FAIL t6_a_data_o got %h exp 0", a_data_o); end
    vec++; if (a_done !== 1'b0) begin err++; $display("FAIL t6_done got %h exp 0", a_done); end
    vec++; if (a_exit_code !== 32'h0) begin err++; $display("FAIL t6_exit_code got %h exp 0", a_exit_code); end
    vec++; if (a_fault !== 1'b0) begin err++; $display("FAIL t6_fault got %h exp 0", a_fault); end
    vec++; if (a_fault_addr !== 32'h0) begin err++; $display("FAIL t6_fault_addr got %h exp 0", a_fault_addr); end
    vec++; if (a_fault_count !== 8'h0) begin err++; $display("FAIL t6_fault_count got %h exp 0", a_fault_count); end
    vec++; if (b_done !== 1'b0 || b_fault_count !== 8'h0) begin err++; $display("FAIL t6_b_sticky got %h/%h exp 0/00", b_done, b_fault_count); end
    drive(32'h0000_0020, 32'h0, 1'b0);
    #1;
    vec++; if (a_t_data_en !== 3'b001) begin err++; $display("FAIL t6_strobe_in_reset got %b exp 001", a_t_data_en); end
    idle();
    for (int k = 0; k < 2; k++) begin
      tick();
      vec++; if (b_rvalid !== 1'b0) begin err++; $display("FAIL t6_b_rvalid_%0d got %h exp 0", k, b_rvalid); end
    end
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      vec++; if (b_rvalid !== 1'b0 || a_rvalid !== 1'b0) begin err++; $display("FAIL t6_post_%0d got %h/%h exp 0/0", k, a_rvalid, b_rvalid); end
    end
  endtask

  initial begin
    test_reset();
    test_region0();
    test_region1();
    test_exit();
    test_unmapped();
    test_boundaries();
    test_back_to_back();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
